cic_decim_mc: RTL and testbench

Multi-channel, parametrised CIC decimator: successor to the single-channel 1-bit PDM CIC. CHANNELS parallel streams share one decimation controller. Order, differential delay and width are compile-time parameters. The ratio is a runtime power of two, and output gain is normalised so full scale is ratio-independent. Sits between the PDM/sigma-delta front end and the downstream FIR/compensation stage, handing off via a valid strobe instead of a derived clock.

---
 rtl/cic_decim_mc.sv | 180 ++++++++++++++++++
 tb/tb_cic_decim_mc.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/cic_decim_mc.sv
// Multi-channel CIC decimator. A shared controller (ratio register, flush,
// decimation counter, warm-up) drives one integrator/comb/normaliser lane per
// channel. The ratio is a runtime power of two, and the output gain is
// normalised so that full scale does not depend on the ratio.

module cic_decim_mc_lane #(
    parameter int IN_W       = 1,
    parameter int ORDER      = 4,
    parameter int DIFF_DELAY = 1,
    parameter int ACC_W      = 26,
    parameter int OUT_W      = 24,
    parameter int SH_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             en,
    input  logic             dec,
    input  logic             load,
    input  logic [SH_W-1:0]  sh,
    input  logic [IN_W-1:0]  x,
    output logic [OUT_W-1:0] y
);
    logic [ACC_W-1:0]                              xin;
    logic [ORDER-1:0][ACC_W-1:0]                   integ, integ_nxt, comb_in;
    logic [ORDER-1:0][DIFF_DELAY-1:0][ACC_W-1:0]   dly;
    logic [ACC_W-1:0]                              comb_out, scaled;

    // A PDM bit maps to +/-1; a wider sample is sign-extended
    if (IN_W == 1) begin : g_pdm
        always_comb xin = x[0] ? ACC_W'(1) : '1;
    end else begin : g_pcm
        always_comb xin = ACC_W'($signed(x));
    end

    // Integrator cascade; the last stage sees this cycle's update
    always_comb begin
        logic [ACC_W-1:0] a;
        a = xin;
        for (int i = 0; i < ORDER; i++) begin
            a            = a + integ[i];
            integ_nxt[i] = a;
        end
    end

    // Comb cascade evaluated on the decimated sample: y = x - x[n-M]
    always_comb begin
        logic [ACC_W-1:0] c;
        c = integ_nxt[ORDER-1];
        for (int s = 0; s < ORDER; s++) begin
            comb_in[s] = c;
            c          = c - dly[s][DIFF_DELAY-1];
        end
        comb_out = c;
    end

    // Gain normalisation: scale up by the ratio deficit, keep the top bits
    always_comb scaled = comb_out << sh;

    // Integrators advance only on accepted input samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       integ <= '0;
        else if (flush) integ <= '0;
        else if (en)    integ <= integ_nxt;
    end

    // Comb delay lines shift once per decimation point
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       dly <= '0;
        else if (flush) dly <= '0;
        else if (dec) begin
            for (int s = 0; s < ORDER; s++) begin
                dly[s][0] <= comb_in[s];
                for (int m = 1; m < DIFF_DELAY; m++) dly[s][m] <= dly[s][m-1];
            end
        end
    end

    // Output register holds between strobes, untouched by a flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      y <= '0;
        else if (load) y <= scaled[ACC_W-1 -: OUT_W];
    end
endmodule

module cic_decim_mc #(
    parameter int CHANNELS   = 2,
    parameter int IN_W       = 1,
    parameter int ORDER      = 4,
    parameter int DIFF_DELAY = 1,
    parameter int MAX_LOG2_R = 8,
    parameter int OUT_W      = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [CHANNELS*IN_W-1:0]  d_in,
    input  logic [3:0]                ratio_log2,
    output logic [CHANNELS*OUT_W-1:0] dout,
    output logic                      dout_valid
);
    localparam int IN_EFF = (IN_W == 1) ? 2 : IN_W;
    localparam int ACC_W  = IN_EFF + ORDER * MAX_LOG2_R;
    localparam int SH_W   = $clog2(ORDER * MAX_LOG2_R + 1);
    localparam int WU     = ORDER * DIFF_DELAY;
    localparam logic [MAX_LOG2_R-1:0] CNT_ONE = 1;

    localparam logic [0:0] ST_WARMUP = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;

    logic [3:0]            k_cl, k_reg, warm;
    logic [0:0]            state;
    logic [MAX_LOG2_R-1:0] cnt, cnt_max;
    logic [MAX_LOG2_R:0]   span;
    logic [SH_W-1:0]       sh;
    logic                  flush, en_acc, dec, load;

    // Clamp the requested ratio into 1..MAX_LOG2_R
    always_comb begin
        if (ratio_log2 == 4'd0)                  k_cl = 4'd1;
        else if (ratio_log2 > 4'(MAX_LOG2_R))    k_cl = 4'(MAX_LOG2_R);
        else                                     k_cl = ratio_log2;
    end

    // Decode flush, decimation point and normaliser shift from k_reg
    always_comb begin
        span    = (MAX_LOG2_R+1)'(1) << k_reg;
        span    = span - (MAX_LOG2_R+1)'(1);
        cnt_max = span[MAX_LOG2_R-1:0];
        flush   = (k_cl != k_reg);
        en_acc  = en && !flush;
        dec     = en_acc && (cnt == cnt_max);
        load    = dec && (state == ST_RUN);
        sh      = SH_W'(ORDER * (MAX_LOG2_R - int'(k_reg)));
    end

    // Ratio register, loaded on the flush cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       k_reg <= 4'd1;
        else if (flush) k_reg <= k_cl;
    end

    // Decimation counter over accepted samples, wraps at the decimation point
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        cnt <= '0;
        else if (flush)  cnt <= '0;
        else if (en_acc) cnt <= dec ? '0 : cnt + CNT_ONE;
    end

    // Warm-up: the first ORDER*M decimation points are discarded
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            warm  <= 4'd0;
            state <= ST_WARMUP;
        end else if (flush) begin
            warm  <= 4'd0;
            state <= ST_WARMUP;
        end else if (dec && state == ST_WARMUP) begin
            warm <= warm + 4'd1;
            if (warm == 4'(WU - 1)) state <= ST_RUN;
        end
    end

    // Output strobe, one cycle after a post-warm-up decimation point
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) dout_valid <= 1'b0;
        else      dout_valid <= load;
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        cic_decim_mc_lane #(
            .IN_W(IN_W), .ORDER(ORDER), .DIFF_DELAY(DIFF_DELAY),
            .ACC_W(ACC_W), .OUT_W(OUT_W), .SH_W(SH_W)
        ) u_lane (
            .clk(clk), .rst(rst), .flush(flush), .en(en_acc), .dec(dec),
            .load(load), .sh(sh), .x(d_in[c*IN_W +: IN_W]),
            .y(dout[c*OUT_W +: OUT_W])
        );
    end
endmodule

// File: tb/tb_cic_decim_mc.sv
// Bench for cic_decim_mc: table of ratio/pattern vectors plus hand-written
// ratio-change and mid-block reset sequences, checked via a scoreboard.

module tb_cic_decim_mc;
    localparam int CH = 2, IN_W = 1, ORDER = 4, DD = 1, MAXK = 6, OUT_W = 24;
    localparam logic [23:0] FS_P = 24'h400000, FS_N = 24'hC00000;

    logic                  clk = 1'b0, rst = 1'b1, en = 1'b0;
    logic [CH*IN_W-1:0]    d_in = '0;
    logic [3:0]            ratio_log2 = 4'd1;
    logic [CH*OUT_W-1:0]   dout;
    logic                  dout_valid;

    cic_decim_mc #(.CHANNELS(CH), .IN_W(IN_W), .ORDER(ORDER), .DIFF_DELAY(DD),
                   .MAX_LOG2_R(MAXK), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .d_in(d_in), .ratio_log2(ratio_log2),
        .dout(dout), .dout_valid(dout_valid));

    always #5 clk = ~clk;

    typedef struct { logic [23:0] e0, e1; } sb_t;
    typedef struct {
        logic [3:0] r; int div; int p0, p1; int n_en;
        logic [23:0] e0, e1; int first_en; int period;
    } vec_t;

    sb_t  sb[$];
    vec_t tbl[6];

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int m_k = 1, m_cnt = 0, m_pts = 0, m_en = 0;
    int cur_first = 0, cur_period = 0, first_seen = 0, last_cyc = 0, n_strobe = 0;
    logic [23:0] cur_e0 = '0, cur_e1 = '0, hold0 = '0, hold1 = '0;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, req);
        end
    endtask

    function automatic int clampk(input logic [3:0] r);
        if (r == 0) return 1;
        if (int'(r) > MAXK) return MAXK;
        return int'(r);
    endfunction

    function automatic logic pbit(input int p, input int n);
        if (p == 0) return 1'b0;
        if (p == 1) return 1'b1;
        return n[0];
    endfunction

    // Drive one cycle, advance the reference controller, check after the edge
    task automatic step(input logic e, input logic [1:0] bits, input logic [3:0] r);
        int  kc;
        sb_t ex;
        logic exp_v;
        en = e; d_in = bits; ratio_log2 = r;
        kc = clampk(r);
        if (kc != m_k) begin
            m_k = kc; m_cnt = 0; m_pts = 0; m_en = 0; first_seen = 0;
        end else if (e) begin
            m_en++; m_cnt++;
            if (m_cnt == (1 << m_k)) begin
                m_cnt = 0; m_pts++;
                if (m_pts > ORDER * DD) sb.push_back('{cur_e0, cur_e1});
            end
        end
        @(posedge clk); #1; cyc++;
        exp_v = (sb.size() != 0);
        cmp("valid", 64'(dout_valid), 64'(exp_v));
        if (dout_valid) begin
            n_strobe++;
            if (first_seen == 0) begin
                cmp("first_en", 64'(m_en), 64'(cur_first));
                first_seen = 1;
            end else cmp("period", 64'(cyc - last_cyc), 64'(cur_period));
            last_cyc = cyc;
        end
        if (exp_v) begin
            ex = sb.pop_front();
            cmp("dout_ch0", 64'(dout[23:0]), 64'(ex.e0));
            cmp("dout_ch1", 64'(dout[47:24]), 64'(ex.e1));
            hold0 = ex.e0; hold1 = ex.e1;
        end else begin
            cmp("hold", 64'(dout), 64'({hold1, hold0}));
        end
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic do_reset();
        rst = 1'b0; #1;
        cmp("rst_valid", 64'(dout_valid), 64'd0);
        cmp("rst_dout", 64'(dout), 64'd0);
        #2; rst = 1'b1;
        m_k = 1; m_cnt = 0; m_pts = 0; m_en = 0; first_seen = 0;
        hold0 = '0; hold1 = '0; n_strobe = 0;
        sb.delete();
    endtask

    initial begin
        int guard;
        // r, en divisor, ch0 pattern, ch1 pattern (0 zeros, 1 ones, 2 alt), en count,
        // expected ch0/ch1, en index of first strobe, strobe period in cycles
        tbl[0] = '{4'd6, 1, 1, 0, 512, FS_P, FS_N, 320, 64};
        tbl[1] = '{4'd3, 1, 1, 0,  80, FS_P, FS_N,  40,  8};
        tbl[2] = '{4'd4, 1, 2, 0, 128, 24'h0, FS_N, 80, 16};
        tbl[3] = '{4'd2, 3, 1, 1,  32, FS_P, FS_P,  20, 12};
        tbl[4] = '{4'd0, 1, 1, 0,  16, FS_P, FS_N,  10,  2};
        tbl[5] = '{4'd9, 1, 0, 1, 384, FS_N, FS_P, 320, 64};

        for (int v = 0; v < 6; v++) begin
            do_reset();
            cur_e0 = tbl[v].e0; cur_e1 = tbl[v].e1;
            cur_first = tbl[v].first_en; cur_period = tbl[v].period;
            guard = 0;
            while (m_en < tbl[v].n_en && guard < 4000) begin
                for (int i = 1; i < tbl[v].div; i++) step(1'b0, 2'($urandom), tbl[v].r);
                step(1'b1, {pbit(tbl[v].p1, m_en + 1), pbit(tbl[v].p0, m_en + 1)}, tbl[v].r);
                guard++;
            end
            cmp("strobes", 64'(n_strobe),
                64'((tbl[v].n_en >> clampk(tbl[v].r)) - ORDER * DD));
        end

        // Ratio 6 -> 2 on the cycle that would be the 7th decimation point
        do_reset();
        cur_e0 = FS_P; cur_e1 = FS_N; cur_first = 320; cur_period = 64;
        guard = 0;
        while (m_en < 447 && guard < 1000) begin step(1'b1, 2'b01, 4'd6); guard++; end
        cmp("pre_change_strobes", 64'(n_strobe), 64'd2);
        n_strobe = 0; cur_first = 20; cur_period = 4;
        step(1'b1, 2'b01, 4'd2);
        guard = 0;
        while (m_en < 32 && guard < 100) begin step(1'b1, 2'b01, 4'd2); guard++; end
        cmp("post_flush_strobes", 64'(n_strobe), 64'd4);

        // Reset right after a strobe, then the full warm-up must repeat
        do_reset();
        cur_e0 = FS_P; cur_e1 = FS_N; cur_first = 40; cur_period = 8;
        guard = 0;
        while (m_en < 48 && guard < 100) begin step(1'b1, 2'b01, 4'd3); guard++; end
        do_reset();
        guard = 0;
        while (m_en < 48 && guard < 100) begin step(1'b1, 2'b01, 4'd3); guard++; end
        cmp("rerun_strobes", 64'(n_strobe), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
